// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock falls and samples the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_AB) ? TIMEOUT_CYCLES : MAX_AB;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST     = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [2:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [8:0]    frame, frame_next;
  logic          data_oe, data_oe_next;
  logic          ack_next, timeout_next;
  logic          clk_s, data_s, fall, accept, expired;

  // Idle bus level is high, so the synchronizers come out of reset high to
  // avoid a phantom falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[1:0], ps2_data_in};
      clk_prev  <= clk_sync[2];
    end
  end

  assign clk_s   = clk_sync[2];
  assign data_s  = data_sync[2];
  assign fall    = clk_prev & ~clk_s;
  assign accept  = tx_valid & (state == IDLE);
  assign expired = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      frame   <= '0;
      data_oe <= 1'b0;
      ack_ok  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_cnt_next;
      frame   <= frame_next;
      data_oe <= data_oe_next;
      ack_ok  <= ack_next;
      timeout <= timeout_next;
    end
  end

  // data_oe is registered and only moves on a fall, so each bit is held
  // across the device's following rising edge.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_cnt_next = bit_cnt;
    frame_next   = frame;
    data_oe_next = data_oe;
    ack_next     = ack_ok;
    timeout_next = timeout;
    case (state)
      IDLE: begin
        data_oe_next = 1'b0;
        if (accept) begin
          frame_next   = {~^tx_data, tx_data};
          ack_next     = 1'b0;
          timeout_next = 1'b0;
          bit_cnt_next = '0;
          cnt_next     = '0;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INHIBIT_LAST) begin
          cnt_next     = '0;
          data_oe_next = 1'b1;
          state_next   = RTS;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RTS: begin
        if (cnt == RTS_LAST) begin
          cnt_next   = '0;
          state_next = SEND;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SEND: begin
        if (fall) begin
          cnt_next = '0;
          if (bit_cnt == 4'd9) begin
            data_oe_next = 1'b0;
            state_next   = ACK;
          end else begin
            data_oe_next = ~frame[bit_cnt];
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else if (expired) begin
          data_oe_next = 1'b0;
          timeout_next = 1'b1;
          ack_next     = 1'b0;
          state_next   = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          ack_next   = ~data_s;
          cnt_next   = '0;
          state_next = WAIT_IDLE;
        end else if (expired) begin
          data_oe_next = 1'b0;
          timeout_next = 1'b1;
          ack_next     = 1'b0;
          state_next   = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_next = DONE;
        end else if (expired) begin
          data_oe_next = 1'b0;
          timeout_next = 1'b1;
          ack_next     = 1'b0;
          state_next   = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        data_oe_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
  assign ps2_data_oe = data_oe;
  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a device model that clocks the
// frame in, plus a per-cycle timeline check of the host's line drive.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, timeout;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_count = 0;
  int done_total = 0;
  int done_cyc = 0;
  int cmp_d;
  logic phase_on = 1'b0;
  logic exp_ack = 1'b0;
  logic exp_timeout = 1'b0;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES(16),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Record every accepted request as seen on the handshake.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_on <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      phase_on  <= 1'b1;
      acc_cyc   <= cyc;
      acc_count <= acc_count + 1;
    end
  end

  // Timeline after accept: 20 cycles inhibit, 16 cycles request, then the
  // clock is released with the start bit still held; a silent device times
  // out 200 cycles after that, i.e. done at cycle 237.
  always @(negedge clk) begin
    if (resetn) begin
      cmp_d = cyc - acc_cyc;
      check_output("ready_vs_busy", tx_ready, !busy);
      if (phase_on && cmp_d >= 1 && cmp_d <= 37) begin
        check_output("clk_oe_timeline", ps2_clk_oe, (cmp_d <= 36));
        check_output("data_oe_timeline", ps2_data_oe, (cmp_d >= 21));
        check_output("busy_timeline", busy, 1);
        if (cmp_d == 1) begin
          check_output("ack_cleared", ack_ok, 0);
          check_output("timeout_cleared", timeout, 0);
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        check_output("done_ack_ok", ack_ok, exp_ack);
        check_output("done_timeout", timeout, exp_timeout);
        check_output("done_clk_oe", ps2_clk_oe, 0);
        check_output("done_data_oe", ps2_data_oe, 0);
        if (exp_timeout) check_output("timeout_cycle", cmp_d, 237);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, then 11 clocks of 40 cycles. Bits are
  // sampled at each rising edge; ACK is driven low ahead of clock 11.
  task automatic run_device(input bit ack, input int abort_at, output logic [10:0] got);
    int n = 0;
    got = '0;
    while (!(clk_line && !data_line) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output("rts_seen", (n < 1000), 1);
    repeat (10) @(negedge clk);
    got[0] = data_line;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (8) @(negedge clk);
        return;
      end
      repeat (20) @(negedge clk);
      if (k <= 10) got[k] = data_line;
      dev_clk_low = 1'b0;
      if (k == 11) begin
        if (ack) begin
          repeat (20) @(negedge clk);
          dev_data_low = 1'b0;
        end
        return;
      end
      repeat (10) @(negedge clk);
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int snap, input bit idle_after);
    int n = 0;
    while (done_total == snap && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("done_seen", (n < 2000), 1);
    repeat (3) @(negedge clk);
    check_output("done_pulses", done_total - snap, 1);
    if (idle_after) begin
      check_output("idle_tx_ready", tx_ready, 1);
      check_output("idle_busy", busy, 0);
      check_output("held_ack_ok", ack_ok, exp_ack);
      check_output("held_timeout", timeout, exp_timeout);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ack, output logic [10:0] got);
    int snap;
    snap = done_total;
    apply_stimulus(b);
    run_device(ack, 0, got);
    check_output("frame_model", got, frame_of(b));
    wait_done(snap, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_tx_ready"}, tx_ready, 1);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_clk_oe"}, ps2_clk_oe, 0);
    check_output({tag, "_data_oe"}, ps2_data_oe, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_ack_ok"}, ack_ok, 0);
    check_output({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    logic [10:0] got;
    int snap;
    int a0;
    resetn       = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    $display("[TB] send 0xED with ACK");
    exp_ack = 1'b1;
    exp_timeout = 1'b0;
    send_frame(8'hED, 1'b1, got);
    check_output("ed_frame_literal", got, 11'b11111011010);

    $display("[TB] send 0x00 without ACK");
    exp_ack = 1'b0;
    send_frame(8'h00, 1'b0, got);
    check_output("zero_frame_literal", got, 11'b11000000000);

    $display("[TB] send 0xFF to a silent device");
    exp_ack = 1'b0;
    exp_timeout = 1'b1;
    snap = done_total;
    apply_stimulus(8'hFF);
    wait_done(snap, 1);

    $display("[TB] reset after fall 5");
    exp_timeout = 1'b0;
    apply_stimulus(8'h0F);
    run_device(1'b0, 5, got);
    check_output("pre_reset_data_oe", ps2_data_oe, 1);
    #2 resetn = 1'b0;
    #1;
    check_output("async_clk_oe", ps2_clk_oe, 0);
    check_output("async_data_oe", ps2_data_oe, 0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("midreset");
    resetn = 1'b1;
    @(negedge clk);
    exp_ack = 1'b1;
    send_frame(8'hF3, 1'b1, got);

    $display("[TB] request while busy, held through done");
    exp_ack = 1'b1;
    exp_timeout = 1'b0;
    snap = done_total;
    a0 = acc_count;
    apply_stimulus(8'h07);
    repeat (5) @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    run_device(1'b1, 0, got);
    check_output("busy_frame_literal", got, 11'b10000001110);
    wait_done(snap, 0);
    check_output("held_request_accepts", acc_count - a0, 2);
    check_output("first_idle_accept", acc_cyc - done_cyc, 1);
    tx_valid = 1'b0;
    run_device(1'b1, 0, got);
    check_output("queued_frame_model", got, frame_of(8'h55));
    wait_done(snap + 1, 1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) to the keyboard on the same two open-drain lines that ps2_keyboard listens on.
- Generates the request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, then samples the device ACK.
- Sits beside ps2_keyboard under top. While busy=1 the receive path must treat bus activity as host traffic.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before request (100 us at 50 MHz).
- RTS_CYCLES, 16, clk cycles data and clock are both held low before clock release.
- TIMEOUT_CYCLES, 750000, maximum clk cycles between consecutive ps2 clock falling edges (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- tx_data  in  8  byte to send; sampled on accept.
- tx_valid  in  1  send request.
- tx_ready  out  1  1 only in IDLE. Accept = tx_valid & tx_ready.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull clock line low, 0 = release.
- ps2_data_oe  out  1  1 = pull data line low, 0 = release.
- busy  out  1  1 in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer ends, for any reason.
- ack_ok  out  1  device ACK result; valid from done until the next accept.
- timeout  out  1  transfer aborted by timeout; valid from done until the next accept.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_ok=0, timeout=0, tx_ready=1.
  - Lines are released in the same cycle reset asserts, including mid-transfer.
- Input sync: ps2_clk_in and ps2_data_in each pass through a 3-flop synchronizer.
  - fall = previous synced clock high & current synced clock low.
  - fall is honoured only in SEND and ACK.
- On accept:
  - Latch frame[8:0] = {parity, tx_data}, with parity = ~^tx_data (odd parity).
  - Clear ack_ok and timeout, zero the bit counter, go to INHIBIT.
- States:
  - IDLE: clk_oe=0, data_oe=0.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
  - RTS: clk_oe=1, data_oe=1 (start bit) for exactly RTS_CYCLES cycles, then SEND.
  - SEND: clk_oe=0; timeout counter cleared on entry and on every fall.
    - Falls 1..9: data_oe = ~frame[n-1] for fall n (data bits LSB first, then parity).
    - Fall 10: data_oe=0 (stop bit, line released), then ACK.
  - ACK: on fall 11, ack_ok = ~synced data (device drives low = ACK), then WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock and synced data are both high, then DONE.
    - Timeout still applies, counted from the last fall.
  - DONE: done=1 for one cycle, then IDLE.
- Timeout: in SEND, ACK or WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES without a fall (or without bus idle in WAIT_IDLE):
  - Release both lines; timeout=1, ack_ok=0; go to DONE.
- Simultaneous events:
  - Fall in the same cycle as counter expiry: the fall wins.
  - tx_valid while busy: ignored; not queued.
  - tx_valid held high through DONE: accepted on the first IDLE cycle.
- Data changes only after a fall, so each bit is stable across the following device rising edge.

Test Plan:
Bench uses INHIBIT_CYCLES=20, RTS_CYCLES=16, TIMEOUT_CYCLES=200, and a device model with a 40-cycle ps2 clock period.
- Reset: resetn=0 then 1, buses high -> tx_ready=1, busy=0, both oe=0, done=0, ack_ok=0, timeout=0.
- Send 0xED with device ACK:
  - clk_oe=1 for 20 cycles, then clk_oe=1 and data_oe=1 for 16 cycles, then clk_oe=0.
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device pulls data low at clock 11 -> one done pulse, ack_ok=1, timeout=0, tx_ready=1.
- Send 0x00 without ACK: device keeps data high at clock 11 -> parity sampled as 1; done pulse, ack_ok=0, timeout=0.
- Device silent: send 0xFF, no ps2 clock edges -> 200 cycles after SEND entry both oe=0, done pulse, timeout=1, ack_ok=0.
- Reset mid-transfer: resetn=0 right after fall 5 -> clk_oe and data_oe are 0 in the same cycle. After release, sending 0xF3 completes with ack_ok=1.
- Busy request: tx_valid with 0x55 during INHIBIT -> ignored, frame still carries the original byte. tx_valid held high through DONE -> 0x55 is accepted on the first IDLE cycle and sent correctly.
